// File: rtl/random_stimulus_bank.sv
// Bank of NUM_CH LFSR/counter stimulus generators plus a MISR signature compactor.
// Latency 1 from advancing edge to rand_out; no backpressure, generators advance whenever mode permits.
module random_stimulus_bank #(
    parameter int                     NUM_CH    = 9,
    parameter int                     WIDTH     = 8,
    parameter logic [WIDTH-1:0]       POLY      = 8'hB8,
    parameter int                     SEED_BASE = 3,
    parameter int                     SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0]   MISR_POLY = 32'h04C11DB7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic                      step,
    input  logic                      reseed,
    output logic [NUM_CH*WIDTH-1:0]   rand_out,
    output logic                      rand_valid,
    input  logic [SIG_WIDTH-1:0]      sig_in,
    input  logic                      sig_en,
    input  logic                      sig_clr,
    output logic [SIG_WIDTH-1:0]      sig_out,
    output logic                      sig_parity,
    output logic [15:0]               adv_count
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_CNT  = 2'b11;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [WIDTH-1:0] seed_of(input int c);
        logic [WIDTH-1:0] s;
        s = WIDTH'(SEED_BASE + 2 * c);
        if (s == '0) begin
            s = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] seed);
        logic [WIDTH-1:0] nxt;
        if (cur == '0) begin
            nxt = seed;
        end else begin
            nxt = (cur >> 1) ^ (cur[0] ? POLY : '0);
        end
        return nxt;
    endfunction

    logic [NUM_CH*WIDTH-1:0] seeds;
    logic [NUM_CH*WIDTH-1:0] state_q, state_d;
    logic                    valid_q, valid_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [SIG_WIDTH-1:0]    sig_q, sig_d;
    logic                    advance;

    always_comb begin
        seeds = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            seeds[c*WIDTH +: WIDTH] = seed_of(c);
        end
    end

    assign advance = (mode == MODE_FREE) || (mode == MODE_CNT) ||
                     ((mode == MODE_STEP) && step);

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (reseed) begin
            state_d = seeds;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (advance) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (mode == MODE_CNT) begin
                    state_d[c*WIDTH +: WIDTH] = state_q[c*WIDTH +: WIDTH] + 1'b1;
                end else begin
                    state_d[c*WIDTH +: WIDTH] = lfsr_next(state_q[c*WIDTH +: WIDTH],
                                                          seeds[c*WIDTH +: WIDTH]);
                end
            end
            valid_d = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Signature path deliberately ignores mode/step/reseed.
    always_comb begin
        sig_d = sig_q;
        if (sig_clr) begin
            sig_d = '0;
        end else if (sig_en) begin
            sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0} ^
                    (sig_q[SIG_WIDTH-1] ? MISR_POLY : '0) ^ sig_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= seeds;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    assign rand_out   = state_q;
    assign rand_valid = valid_q;
    assign adv_count  = cnt_q;
    assign sig_out    = sig_q;
    assign sig_parity = ^sig_q;

endmodule

// File: tb/tb_random_stimulus_bank.sv
// Directed and randomized checks of random_stimulus_bank against an arithmetic reference model.
module tb_random_stimulus_bank;

    localparam int NCH = 9;

    logic            clk;
    logic            reset;
    logic [1:0]      mode;
    logic            step;
    logic            reseed;
    logic [NCH*8-1:0] rand_out;
    logic            rand_valid;
    logic [31:0]     sig_in;
    logic            sig_en;
    logic            sig_clr;
    logic [31:0]     sig_out;
    logic            sig_parity;
    logic [15:0]     adv_count;

    int n_assert = 0;
    int n_fail   = 0;

    int          mch [NCH];
    int          mcnt;
    bit          mvalid;
    bit [31:0]   msig;

    random_stimulus_bank dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .step       (step),
        .reseed     (reseed),
        .rand_out   (rand_out),
        .rand_valid (rand_valid),
        .sig_in     (sig_in),
        .sig_en     (sig_en),
        .sig_clr    (sig_clr),
        .sig_out    (sig_out),
        .sig_parity (sig_parity),
        .adv_count  (adv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int seed(input int c);
        int s;
        s = (3 + 2 * c) % 256;
        if (s == 0) s = 1;
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mch[c] = seed(c);
        mcnt   = 0;
        mvalid = 0;
        msig   = 0;
    endtask

    task automatic model_step(input int m, input bit s, input bit rs,
                              input bit se, input bit sc, input bit [31:0] si);
        bit adv;
        bit [32:0] t;
        adv = (m == 1) || (m == 3) || (m == 2 && s);
        if (rs) begin
            for (int c = 0; c < NCH; c++) mch[c] = seed(c);
            mcnt   = 0;
            mvalid = 1;
        end else if (adv) begin
            for (int c = 0; c < NCH; c++) begin
                if (m == 3)             mch[c] = (mch[c] + 1) % 256;
                else if (mch[c] == 0)   mch[c] = seed(c);
                else                    mch[c] = (mch[c] / 2) ^ ((mch[c] % 2 == 1) ? 'hB8 : 0);
            end
            mcnt   = (mcnt < 65535) ? mcnt + 1 : 65535;
            mvalid = 1;
        end else begin
            mvalid = 0;
        end
        if (sc) begin
            msig = 0;
        end else if (se) begin
            t    = {msig, 1'b0};
            msig = t[31:0] ^ (t[32] ? 32'h04C11DB7 : 32'h0) ^ si;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s_ch%0d", tag, c), {24'h0, rand_out[c*8 +: 8]}, mch[c]);
        chk({tag, "_valid"},  {31'h0, rand_valid}, {31'h0, mvalid});
        chk({tag, "_cnt"},    {16'h0, adv_count},  mcnt);
        chk({tag, "_sig"},    sig_out,             msig);
        chk({tag, "_parity"}, {31'h0, sig_parity}, {31'h0, ^msig});
    endtask

    task automatic tick(input logic [1:0] m, input logic s, input logic rs,
                        input logic se, input logic sc, input logic [31:0] si);
        mode = m; step = s; reseed = rs; sig_en = se; sig_clr = sc; sig_in = si;
        @(posedge clk);
        #1;
        model_step(m, s, rs, se, sc, si);
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; step = 1'b0; reseed = 1'b0;
        sig_in = '0; sig_en = 1'b0; sig_clr = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(negedge clk);
        reset = 1'b0;

        // Hold after release
        for (int i = 0; i < 5; i++) begin
            tick(2'b00, 0, 0, 0, 0, 0);
            check_all("hold");
        end
        chk("hold_ch0", {24'h0, rand_out[7:0]},   32'h03);
        chk("hold_ch1", {24'h0, rand_out[15:8]},  32'h05);
        chk("hold_ch8", {24'h0, rand_out[71:64]}, 32'h13);

        // Free-run two advances
        tick(2'b01, 0, 0, 0, 0, 0);
        check_all("free1");
        chk("free1_ch0", {24'h0, rand_out[7:0]},  32'hB9);
        chk("free1_ch1", {24'h0, rand_out[15:8]}, 32'hBA);
        tick(2'b01, 0, 0, 0, 0, 0);
        check_all("free2");
        chk("free2_ch0", {24'h0, rand_out[7:0]}, 32'hE4);
        chk("free2_cnt", {16'h0, adv_count},     32'd2);

        // Step mode from fresh seeds
        tick(2'b00, 0, 1, 0, 0, 0);
        check_all("reseed0");
        for (int i = 1; i <= 6; i++) begin
            tick(2'b10, (i == 2 || i == 5), 0, 0, 0, 0);
            check_all($sformatf("step%0d", i));
        end
        chk("step_ch0", {24'h0, rand_out[7:0]}, 32'hE4);
        chk("step_cnt", {16'h0, adv_count},     32'd2);

        // Counter up to 0xFF, wrap, then LFSR lock-up escape
        for (int i = 0; i < 300 && mch[0] != 255; i++) begin
            tick(2'b11, 0, 0, 0, 0, 0);
            check_all("cnt");
        end
        chk("cnt_reach_ff", {24'h0, rand_out[7:0]}, 32'hFF);
        tick(2'b11, 0, 0, 0, 0, 0);
        check_all("cnt_wrap");
        chk("cnt_wrap_ch0", {24'h0, rand_out[7:0]}, 32'h00);
        tick(2'b01, 0, 0, 0, 0, 0);
        check_all("lockup");
        chk("lockup_ch0", {24'h0, rand_out[7:0]}, 32'h03);

        // Randomized mix
        for (int i = 0; i < 200; i++) begin
            tick(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $urandom);
            check_all("rand");
        end

        // Reseed overrides free-run advance
        tick(2'b00, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(2'b01, 0, 0, 0, 0, 0);
        check_all("pre_reseed");
        tick(2'b01, 0, 1, 0, 0, 0);
        check_all("reseed_ovr");
        chk("reseed_ch0",   {24'h0, rand_out[7:0]}, 32'h03);
        chk("reseed_cnt",   {16'h0, adv_count},     32'd0);
        chk("reseed_valid", {31'h0, rand_valid},    32'd1);

        // Signature directed
        tick(2'b00, 0, 0, 0, 1, 0);
        check_all("sig_clr");
        tick(2'b00, 0, 0, 1, 0, 32'h1);
        check_all("sig_a");
        chk("sig_a_val", sig_out, 32'h1);
        chk("sig_a_par", {31'h0, sig_parity}, 32'd1);
        tick(2'b00, 0, 0, 1, 0, 32'h1);
        check_all("sig_b");
        chk("sig_b_val", sig_out, 32'h3);
        chk("sig_b_par", {31'h0, sig_parity}, 32'd0);
        tick(2'b01, 0, 1, 1, 1, 32'hDEADBEEF);
        check_all("sig_both");
        chk("sig_both_val", sig_out, 32'h0);

        // Saturation
        for (int i = 0; i < 70000; i++) tick(2'b01, 0, 0, 0, 0, 0);
        check_all("sat");
        chk("sat_cnt", {16'h0, adv_count}, 32'hFFFF);
        tick(2'b11, 0, 0, 0, 0, 0);
        tick(2'b01, 0, 0, 0, 0, 0);
        check_all("sat_hold");

        // Asynchronous reset between edges during free-run
        tick(2'b01, 0, 0, 1, 0, 32'h1234);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset");
        #1;
        reset = 1'b0;
        tick(2'b01, 0, 0, 0, 0, 0);
        check_all("post_reset");
        chk("post_reset_ch0", {24'h0, rand_out[7:0]}, 32'hB9);
        chk("post_reset_cnt", {16'h0, adv_count},     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/random_stimulus_bank.md
RANDOM_STIMULUS_BANK -- requirements
Module: random_stimulus_bank

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_CH      9      number of independent generator channels
  WIDTH       8      bits per channel
  POLY        8'hB8  Galois feedback taps (WIDTH bits)
  SEED_BASE   3      channel c seed = SEED_BASE + 2*c, masked to WIDTH; 0 replaced by 1
  SIG_WIDTH   32     signature register width
  MISR_POLY   32'h04C11DB7  signature feedback taps (SIG_WIDTH bits)
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  clk        in   1               sole clock, all state rising-edge
  reset      in   1               asynchronous, active-high
  mode       in   2               00 hold, 01 free-run LFSR, 10 step LFSR, 11 counter
  step       in   1               advance request, used in mode 10
  reseed     in   1               reload all channel seeds
  rand_out   out  NUM_CH*WIDTH    channel c at bits [c*WIDTH +: WIDTH], registered
  rand_valid out  1               high the cycle after channel states changed
  sig_in     in   SIG_WIDTH       DUT outputs to compact
  sig_en     in   1               fold sig_in into signature
  sig_clr    in   1               clear signature
  sig_out    out  SIG_WIDTH       signature register
  sig_parity out  1               XOR-reduce of sig_out, combinational from register
  adv_count  out  16              number of advances since reset/reseed, saturating
REQ-003 One clock domain; reset SHALL be asynchronous and active-high; no other reset exists.

Function
REQ-010 An advance SHALL occur in a cycle when mode=01, or mode=10 with step=1, or mode=11; mode=00 or mode=10 with step=0 SHALL hold all channel states.
REQ-011 LFSR advance (modes 01/10) per channel: next = (state >> 1) ^ (state[0] ? POLY : 0).
REQ-012 LFSR advance from state 0 SHALL load that channel's seed instead (lock-up escape).
REQ-013 Counter advance (mode 11): next = state + 1 mod 2^WIDTH; 0xFF..F wraps to 0 with no special handling.
REQ-014 All channels SHALL advance in the same cycle; rand_out reflects new state one clock after the advancing edge (latency 1).
REQ-015 reseed=1 SHALL load every channel with its seed and clear adv_count, overriding any advance in that cycle; rand_valid SHALL be high the following cycle.
REQ-016 rand_valid SHALL be a registered flag: 1 the cycle after any advance or reseed, else 0.
REQ-017 adv_count SHALL increment by 1 per advance and saturate at 16'hFFFF.
REQ-018 Mode changes SHALL take effect on the edge where the new value is sampled; no pipeline of mode.
REQ-019 Signature when sig_en=1: sig = ((sig << 1) ^ (sig[MSB] ? MISR_POLY : 0)) ^ sig_in; hold when sig_en=0.
REQ-020 sig_clr=1 SHALL set sig_out to 0 and take priority over sig_en in the same cycle.
REQ-021 Signature path SHALL be independent of mode, step and reseed.

Reset
REQ-030 During reset: each channel = its seed, rand_valid=0, adv_count=0, sig_out=0; assertion acts without a clock edge.
REQ-031 Reset asserted mid-advance SHALL discard the pending update; first advance after release uses seed as current state.

Verification (defaults, WIDTH=8, POLY=8'hB8)
REQ-040 Reset release, mode=00 for 5 cycles -> ch0=0x03, ch1=0x05, ch8=0x13, rand_valid=0, adv_count=0.
REQ-041 mode=01 for 2 cycles -> ch0 0x03->0xB9->0xE4, ch1 0x05->0xBA, rand_valid=1 each following cycle, adv_count=2.
REQ-042 mode=10, step pulses on cycles 2 and 5 of 6 -> exactly two advances, ch0=0xE4, adv_count=2; mode=11 from ch0=0xFF -> 0x00, then mode=01 -> ch0=0x03.
REQ-043 reseed=1 with mode=01 in same cycle after 10 advances -> ch0=0x03, adv_count=0, rand_valid=1 next cycle; 70000 free-run cycles -> adv_count=0xFFFF held.
REQ-044 sig_clr, then sig_en with sig_in=0x00000001 twice -> sig_out 0x1 then 0x3, sig_parity 1 then 0; sig_en and sig_clr together -> sig_out=0.
REQ-045 Assert reset asynchronously between edges during free-run -> all outputs at reset values before next edge; release -> ch0 advances 0x03->0xB9.
